axi_st_llink_tx_pipe: RTL and testbench

//  Parametrised AXI-Stream master to Logic Link TX adapter. It packs tkeep/tdata/tuser into one TX FIFO word.
//  A 2-entry skid buffer gives a registered user_tready. Optional null-beat filter drops tkeep==0 beats.
//  In Gen1 mode the Logic Link side is paced to one beat every other cycle. Saturating beat and drop counters are included.

---
 rtl/axi_st_llink_tx_pipe.sv | 166 ++++++++++++++++
 tb/tb_axi_st_llink_tx_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_st_llink_tx_pipe.sv
// rtl/axi_st_llink_tx_pipe.sv - AXI-Stream to Logic Link TX adapter with skid buffer, null filter and Gen1 pacing
//
// Purpose:
//   Accepts beats from an AXI-Stream source and packs tkeep/tdata/tuser into
//   one Logic Link TX FIFO word. A two-entry buffer (main + skid) lets
//   user_tready come straight from a flop without losing beats. With
//   KEEP_EN=1, beats whose tkeep is all zero are consumed and dropped. In
//   Gen1 mode the output side only presents data on every other cycle.
//   Saturating counters report beats sent and null beats dropped.
//
// Ports:
//   clk_wr          single clock, all state on the rising edge
//   rst_wr_n        asynchronous active-low reset
//   user_tkeep      AXI-ST byte enables (ignored when KEEP_EN=0)
//   user_tdata      AXI-ST data
//   user_tuser      AXI-ST sideband
//   user_tvalid     AXI-ST valid
//   user_tready     AXI-ST ready, straight from a flop
//   user_st_vld     Logic Link TX valid
//   txfifo_st_data  packed Logic Link TX word
//   user_st_ready   Logic Link TX ready
//   m_gen2_mode     1 = Gen2 (no pacing), 0 = Gen1 (half-rate pacing)
//   beat_cnt        beats sent on Logic Link, saturating
//   drop_cnt        null beats filtered, saturating

module axi_st_llink_tx_pipe #(
  parameter int TDATA_W = 128,
  parameter int TUSER_W = 1,
  parameter int KEEP_EN = 1,
  parameter int TKEEP_W = TDATA_W / 8,
  parameter int PKT_W   = KEEP_EN * TKEEP_W + TDATA_W + TUSER_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk_wr,
  input  logic               rst_wr_n,
  input  logic [TKEEP_W-1:0] user_tkeep,
  input  logic [TDATA_W-1:0] user_tdata,
  input  logic [TUSER_W-1:0] user_tuser,
  input  logic               user_tvalid,
  output logic               user_tready,
  output logic               user_st_vld,
  output logic [PKT_W-1:0]   txfifo_st_data,
  input  logic               user_st_ready,
  input  logic               m_gen2_mode,
  output logic [CNT_W-1:0]   beat_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Main register feeds the output; skid register catches the one beat
  // that can arrive while ready is still high but main cannot drain.
  logic             m_v_q, m_v_d;
  logic [PKT_W-1:0] m_d_q, m_d_d;
  logic             s_v_q, s_v_d;
  logic [PKT_W-1:0] s_d_q, s_d_d;
  logic             rdy_q, rdy_d;
  logic             pace_q, pace_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [PKT_W-1:0] pkt_in;
  logic             is_null;
  logic             acc_in;
  logic             acc_out;
  logic             store;

  generate
    if (KEEP_EN != 0) begin : g_keep
      assign pkt_in  = {user_tuser, user_tdata, user_tkeep};
      assign is_null = (user_tkeep == '0);
    end else begin : g_nokeep
      assign pkt_in  = {user_tuser, user_tdata};
      assign is_null = 1'b0;
    end
  endgenerate

  assign acc_in  = user_tvalid & rdy_q;
  assign acc_out = user_st_vld & user_st_ready;
  // Null beats are consumed at the handshake but never occupy a register.
  assign store   = acc_in & ~is_null;

  assign user_tready    = rdy_q;
  assign user_st_vld    = m_v_q & pace_q;
  assign txfifo_st_data = m_d_q;
  assign beat_cnt       = beat_cnt_q;
  assign drop_cnt       = drop_cnt_q;

  always_comb begin
    m_v_d = m_v_q;
    m_d_d = m_d_q;
    s_v_d = s_v_q;
    s_d_d = s_d_q;
    if (acc_out) begin
      if (s_v_q) begin
        // Skid advances into main; a new beat refills skid behind it.
        m_v_d = 1'b1;
        m_d_d = s_d_q;
        s_v_d = store;
        if (store) begin
          s_d_d = pkt_in;
        end
      end else begin
        // Main drains and is replaced in the same edge; skid stays empty.
        m_v_d = store;
        if (store) begin
          m_d_d = pkt_in;
        end
      end
    end else if (store) begin
      // rdy_q is low whenever skid is full, so a store here always fits.
      if (!m_v_q) begin
        m_v_d = 1'b1;
        m_d_d = pkt_in;
      end else begin
        s_v_d = 1'b1;
        s_d_d = pkt_in;
      end
    end
  end

  // Ready only drops once skid is holding a beat, so any beat accepted
  // while ready was high always has a register to land in.
  assign rdy_d = ~s_v_d;

  // Free-running toggle in Gen1, regardless of whether data is present.
  assign pace_d = m_gen2_mode ? 1'b1 : ~pace_q;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (acc_out && (beat_cnt_q != CNT_MAX)) begin
      beat_cnt_d = beat_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (acc_in && is_null && (drop_cnt_q != CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      m_v_q      <= 1'b0;
      m_d_q      <= '0;
      s_v_q      <= 1'b0;
      s_d_q      <= '0;
      rdy_q      <= 1'b0;
      pace_q     <= 1'b1;
      beat_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      m_v_q      <= m_v_d;
      m_d_q      <= m_d_d;
      s_v_q      <= s_v_d;
      s_d_q      <= s_d_d;
      rdy_q      <= rdy_d;
      pace_q     <= pace_d;
      beat_cnt_q <= beat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_st_llink_tx_pipe.sv
// tb/tb_axi_st_llink_tx_pipe.sv - self-checking bench for axi_st_llink_tx_pipe

module tb_axi_st_llink_tx_pipe;

  localparam int TDATA_W = 128;
  localparam int TUSER_W = 1;
  localparam int KEEP_EN = 1;
  localparam int TKEEP_W = TDATA_W / 8;
  localparam int PKT_W   = KEEP_EN * TKEEP_W + TDATA_W + TUSER_W;
  localparam int CNT_W   = 4;
  localparam int CMAX    = 15;

  logic               clk_wr = 1'b0;
  logic               rst_wr_n = 1'b0;
  logic [TKEEP_W-1:0] user_tkeep = '0;
  logic [TDATA_W-1:0] user_tdata = '0;
  logic [TUSER_W-1:0] user_tuser = '0;
  logic               user_tvalid = 1'b0;
  logic               user_tready;
  logic               user_st_vld;
  logic [PKT_W-1:0]   txfifo_st_data;
  logic               user_st_ready = 1'b1;
  logic               m_gen2_mode = 1'b1;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   drop_cnt;

  axi_st_llink_tx_pipe #(
    .TDATA_W(TDATA_W), .TUSER_W(TUSER_W), .KEEP_EN(KEEP_EN), .CNT_W(CNT_W)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
    .user_tkeep(user_tkeep), .user_tdata(user_tdata), .user_tuser(user_tuser),
    .user_tvalid(user_tvalid), .user_tready(user_tready),
    .user_st_vld(user_st_vld), .txfifo_st_data(txfifo_st_data),
    .user_st_ready(user_st_ready), .m_gen2_mode(m_gen2_mode),
    .beat_cnt(beat_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  int total = 0;
  int bad = 0;

  task automatic chk_s(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_p(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: the two registers are just an ordered queue of at most two
  // stored packets; ready means "fewer than two stored after this edge".
  logic [PKT_W-1:0] mq[$];
  bit m_rdy = 1'b0;
  bit m_pace = 1'b1;
  int m_beats = 0;
  int m_drops = 0;
  int sent_log[$];

  always @(negedge clk_wr) begin
    bit ai, ao, exp_vld;
    if (!rst_wr_n) begin
      mq.delete();
      m_rdy = 1'b0;
      m_pace = 1'b1;
      m_beats = 0;
      m_drops = 0;
    end
    exp_vld = (mq.size() > 0) && m_pace;
    chk_s("tready", int'(user_tready), int'(m_rdy));
    chk_s("st_vld", int'(user_st_vld), int'(exp_vld));
    if (exp_vld) chk_p("st_data", txfifo_st_data, mq[0]);
    chk_s("beat_cnt", int'(beat_cnt), m_beats);
    chk_s("drop_cnt", int'(drop_cnt), m_drops);
    if (user_st_vld && user_st_ready) sent_log.push_back(int'(txfifo_st_data[TKEEP_W +: 32]));
    if (rst_wr_n) begin
      ai = user_tvalid && m_rdy;
      ao = exp_vld && user_st_ready;
      if (ao) begin
        void'(mq.pop_front());
        if (m_beats < CMAX) m_beats++;
      end
      if (ai) begin
        if (user_tkeep == '0) begin
          if (m_drops < CMAX) m_drops++;
        end else begin
          mq.push_back({user_tuser, user_tdata, user_tkeep});
        end
      end
      m_rdy = (mq.size() < 2);
      m_pace = m_gen2_mode ? 1'b1 : ~m_pace;
    end
  end

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic drive(input logic v, input logic [TKEEP_W-1:0] k, input int d);
    user_tvalid = v;
    user_tkeep = k;
    user_tdata = TDATA_W'(d);
    user_tuser = TUSER_W'(d & 1);
  endtask

  task automatic idle();
    user_tvalid = 1'b0;
  endtask

  task automatic wait_acc(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk_wr);
      if (user_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_wr);
    #1;
    chk_s({nm, "_accept"}, int'(ok), 1);
  endtask

  task automatic send(input logic [TKEEP_W-1:0] k, input int d);
    drive(1'b1, k, d);
    wait_acc("send");
  endtask

  task automatic do_reset();
    idle();
    rst_wr_n = 1'b0;
    repeat (2) @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;
    step();
    sent_log.delete();
  endtask

  task automatic chk_log(input string nm, input int exp[$]);
    chk_s({nm, "_len"}, sent_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sent_log.size(); i++)
      chk_s($sformatf("%s_%0d", nm, i), sent_log[i], exp[i]);
  endtask

  initial begin
    bit a, prev;
    int d;

    // 1. Reset and release
    repeat (3) @(posedge clk_wr);
    #1;
    chk_s("t1_rst_rdy", int'(user_tready), 0);
    chk_s("t1_rst_vld", int'(user_st_vld), 0);
    chk_p("t1_rst_data", txfifo_st_data, '0);
    chk_s("t1_rst_beats", int'(beat_cnt), 0);
    chk_s("t1_rst_drops", int'(drop_cnt), 0);
    rst_wr_n = 1'b1;
    @(negedge clk_wr);
    chk_s("t1_rdy_pre", int'(user_tready), 0);
    step();
    chk_s("t1_rdy_post", int'(user_tready), 1);
    sent_log.delete();

    // 2. Gen2 back-to-back
    for (int i = 0; i < 8; i++) begin
      send('1, i);
      if (i == 0) chk_s("t2_latency", int'(user_st_vld), 1);
    end
    idle();
    repeat (4) step();
    chk_s("t2_beats", int'(beat_cnt), 8);
    chk_log("t2_order", '{0, 1, 2, 3, 4, 5, 6, 7});

    // 3. Stall with three beats offered
    user_st_ready = 1'b0;
    sent_log.delete();
    send('1, 0);
    send('1, 1);
    chk_s("t3_rdy_full", int'(user_tready), 0);
    drive(1'b1, '1, 2);
    repeat (3) step();
    chk_s("t3_rdy_hold", int'(user_tready), 0);
    chk_s("t3_beats_hold", int'(beat_cnt), 8);
    user_st_ready = 1'b1;
    wait_acc("t3_b2");
    idle();
    repeat (4) step();
    chk_log("t3_order", '{0, 1, 2});
    chk_s("t3_beats", int'(beat_cnt), 11);

    // 4. Gen1 pacing, continuous input
    m_gen2_mode = 1'b0;
    do_reset();
    d = 0;
    drive(1'b1, '1, d);
    prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_wr);
      a = user_tready;
      chk_s("t4_gap", int'(prev && user_st_vld), 0);
      prev = user_st_vld;
      @(posedge clk_wr);
      #1;
      if (a) begin
        d++;
        drive(1'b1, '1, d);
      end
    end
    chk_s("t4_beats", int'(beat_cnt), 6);
    chk_log("t4_order", '{0, 1, 2, 3, 4, 5});
    idle();
    m_gen2_mode = 1'b1;
    repeat (6) step();

    // 5. Null filter
    do_reset();
    send(16'hFFFF, 'hA);
    chk_p("t5_pack", txfifo_st_data, {1'b0, 128'hA, 16'hFFFF});
    send(16'h0000, 'hB);
    send(16'h00FF, 'hC);
    idle();
    repeat (4) step();
    chk_s("t5_drops", int'(drop_cnt), 1);
    chk_s("t5_beats", int'(beat_cnt), 2);
    chk_log("t5_order", '{'hA, 'hC});

    // 6. Async reset with both registers full
    do_reset();
    user_st_ready = 1'b0;
    send(16'h0000, 'h55);
    send('1, 1);
    send('1, 2);
    idle();
    chk_s("t6_rdy_full", int'(user_tready), 0);
    step();
    #2;
    rst_wr_n = 1'b0;
    #1;
    chk_s("t6_rst_vld", int'(user_st_vld), 0);
    chk_s("t6_rst_rdy", int'(user_tready), 0);
    chk_p("t6_rst_data", txfifo_st_data, '0);
    chk_s("t6_rst_beats", int'(beat_cnt), 0);
    chk_s("t6_rst_drops", int'(drop_cnt), 0);
    repeat (2) @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;
    step();
    user_st_ready = 1'b1;
    sent_log.delete();
    send('1, 7);
    idle();
    repeat (3) step();
    chk_log("t6_clean", '{7});
    chk_s("t6_beats", int'(beat_cnt), 1);

    // 7. Counter saturation
    for (int i = 0; i < 17; i++) send('1, 100 + i);
    for (int i = 0; i < 17; i++) send('0, i);
    idle();
    repeat (4) step();
    chk_s("t7_beat_sat", int'(beat_cnt), CMAX);
    chk_s("t7_drop_sat", int'(drop_cnt), CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
